// File: rtl/mult_issue_if.sv
// Handshake bundle between the operand sequencer, its producer, the
// multiplier and the result consumer. MULT_ISSUE_TAG_EN adds the tag lanes.
interface mult_issue_if
`ifdef MULT_ISSUE_TAG_EN
  #(parameter int TAG_W = 4)
`endif
  ;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_mlier;
  logic [31:0] op_mcand;
  logic        mult_start;
  logic [31:0] mult_mlier;
  logic [31:0] mult_mcand;
  logic        mult_valid;
  logic [63:0] mult_prodt;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_prodt;
  logic        busy;
`ifdef MULT_ISSUE_TAG_EN
  logic [TAG_W-1:0] op_tag;
  logic [TAG_W-1:0] res_tag;
`endif

  modport master (
    input  op_valid, op_mlier, op_mcand,
`ifdef MULT_ISSUE_TAG_EN
    input  op_tag,
    output res_tag,
`endif
    input  mult_valid, mult_prodt, res_ready,
    output op_ready, mult_start, mult_mlier,
    output mult_mcand, res_valid, res_prodt,
    output busy
  );

  modport slave (
    output op_valid, op_mlier, op_mcand,
`ifdef MULT_ISSUE_TAG_EN
    output op_tag,
    input  res_tag,
`endif
    output mult_valid, mult_prodt, res_ready,
    input  op_ready, mult_start, mult_mlier,
    input  mult_mcand, res_valid, res_prodt,
    input  busy
  );
endinterface

// File: rtl/mult_issue.sv
// Operand FIFO + issue FSM in front of the shift-add multiplier.
// Optional per-op tag path enabled by MULT_ISSUE_TAG_EN.
module mult_issue #(
  parameter int DEPTH    = 4,
  parameter int CAPT_DLY = 1,
  parameter int GAP      = 1
`ifdef MULT_ISSUE_TAG_EN
  , parameter int TAG_W  = 4
`endif
) (
  input logic   clock,
  input logic   reset_n,
  mult_issue_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMAX = (CAPT_DLY > GAP) ? CAPT_DLY : GAP;
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_WAIT, S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_dec;
  logic          start_q, start_d;
  logic [31:0]   mlier_q, mlier_d;
  logic [31:0]   mcand_q, mcand_d;
  logic          rvalid_q, rvalid_d;
  logic [63:0]   prodt_q, prodt_d;
  logic [31:0]   fifo_mlier_q [DEPTH];
  logic [31:0]   fifo_mcand_q [DEPTH];
`ifdef MULT_ISSUE_TAG_EN
  logic [TAG_W-1:0] fifo_tag_q [DEPTH];
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] rtag_q, rtag_d;
`endif
  logic full, empty, push, pop, cap;

  always_comb begin
    full  = (count_q == (AW+1)'(DEPTH));
    empty = (count_q == '0);
    pop   = (state_q == S_IDLE) && !empty;
    push  = bus.op_valid && bus.op_ready;
  end

  // A full FIFO still takes a push on the cycle it pops
  assign bus.op_ready = !full || pop;

  always_comb begin
    cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
    cap = (state_q == S_WAIT) && (cnt_dec == '0)
          && (!rvalid_q || bus.res_ready);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push)
               - (AW+1)'(pop);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    mlier_d = mlier_q;
    mcand_d = mcand_q;
`ifdef MULT_ISSUE_TAG_EN
    tag_d   = tag_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          mlier_d = fifo_mlier_q[rd_ptr_q];
          mcand_d = fifo_mcand_q[rd_ptr_q];
`ifdef MULT_ISSUE_TAG_EN
          tag_d   = fifo_tag_q[rd_ptr_q];
`endif
          start_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.mult_valid) begin
          cnt_d   = CW'(CAPT_DLY);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_dec;
        if (cap) begin
          start_d = 1'b0;
          // IDLE supplies the final low cycle before reissue
          if (GAP > 1) begin
            cnt_d   = CW'(GAP - 2);
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rvalid_d = rvalid_q;
    prodt_d  = prodt_q;
`ifdef MULT_ISSUE_TAG_EN
    rtag_d   = rtag_q;
`endif
    if (cap) begin
      rvalid_d = 1'b1;
      prodt_d  = bus.mult_prodt;
`ifdef MULT_ISSUE_TAG_EN
      rtag_d   = tag_q;
`endif
    end else if (bus.res_ready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      mlier_q  <= '0;
      mcand_q  <= '0;
      rvalid_q <= 1'b0;
      prodt_q  <= '0;
`ifdef MULT_ISSUE_TAG_EN
      tag_q    <= '0;
      rtag_q   <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mlier_q[i] <= '0;
        fifo_mcand_q[i] <= '0;
`ifdef MULT_ISSUE_TAG_EN
        fifo_tag_q[i]   <= '0;
`endif
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      mlier_q  <= mlier_d;
      mcand_q  <= mcand_d;
      rvalid_q <= rvalid_d;
      prodt_q  <= prodt_d;
`ifdef MULT_ISSUE_TAG_EN
      tag_q    <= tag_d;
      rtag_q   <= rtag_d;
`endif
      if (push) begin
        fifo_mlier_q[wr_ptr_q] <= bus.op_mlier;
        fifo_mcand_q[wr_ptr_q] <= bus.op_mcand;
`ifdef MULT_ISSUE_TAG_EN
        fifo_tag_q[wr_ptr_q]   <= bus.op_tag;
`endif
      end
    end
  end

  assign bus.mult_start = start_q;
  assign bus.mult_mlier = mlier_q;
  assign bus.mult_mcand = mcand_q;
  assign bus.res_valid  = rvalid_q;
  assign bus.res_prodt  = prodt_q;
  assign bus.busy = !empty || (state_q != S_IDLE);
`ifdef MULT_ISSUE_TAG_EN
  assign bus.res_tag = rtag_q;
`endif
endmodule
